arm_seq_ctrl: RTL
=================

Name: arm_seq_ctrl

Overview:
Instruction sequencer for the 16-bit Harvard datapath. It fetches instructions from instruction memory over a valid-qualified request. It holds the current instruction in an instruction register (IR) that drives the ALU `inst` input, and pulses `exec1` for one cycle per executed instruction. It also stalls on load instructions until data memory acknowledges, and handles non-ALU control instructions (jump, halt).

Parameters:
ADDR_W, 8, width of the program counter and instruction-memory address
RESET_PC, 0, PC value loaded on reset (truncated to ADDR_W bits)

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level enable; sampled at instruction boundaries
imem_req  output  1  fetch request, high while in FETCH
imem_addr  output  ADDR_W  fetch address, equals pc
imem_rdata  input  16  fetched instruction word
imem_valid  input  1  imem_rdata valid this cycle; ignored unless imem_req=1
inst  output  16  instruction register, drives ALU inst
exec1  output  1  one-cycle execute strobe to ALU
dmem_req  output  1  load request, high while in MEMWAIT
dmem_ack  input  1  load complete; ignored unless dmem_req=1
pc  output  ADDR_W  current program counter
halted  output  1  high while in HALT

Behaviour:
- States: IDLE, FETCH, EXEC1, MEMWAIT, HALT.
- Reset (synchronous, active-high):
  - state=IDLE, pc=RESET_PC, inst=16'h0000.
  - exec1=0, imem_req=0, dmem_req=0, halted=0.
  - Reset overrides every state, including mid-fetch and MEMWAIT; a pending request is simply dropped.
- All outputs are registered or decoded purely from state; no combinational path from any input to any output.
- IDLE: run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid=1: inst<=imem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W, so 2^ADDR_W-1 -> 0), -> EXEC1.
  - Otherwise stay, with inst and pc held.
- EXEC1 (exec1=1 for exactly this one cycle), decode inst:
  - inst[15:13]=3'b101 (load) -> MEMWAIT.
  - inst[15]=1, any other op -> boundary.
  - inst[15:14]=2'b00 (jump) -> pc<=inst[ADDR_W-1:0], overriding the increment; then boundary.
  - inst[15:14]=2'b01 (halt) -> HALT.
- MEMWAIT:
  - dmem_req=1 until dmem_ack=1; on ack -> boundary.
  - inst is held stable throughout, so the ALU load/wen decode stays valid.
- Boundary: run=1 -> FETCH; run=0 -> IDLE. Deasserting run never aborts an instruction in flight.
- HALT: halted=1, no requests; sticky until reset. run is ignored.
- Minimum throughput: 2 cycles per ALU or jump instruction when imem_valid returns immediately; 3+ cycles per load.
- Any imem_valid or dmem_ack seen outside its request state is ignored and produces no state change.

Optional Feature:
STEP_MODE_EN — adds input `step` (1 bit).
- Compiled in: at a boundary with run=1, the controller goes to IDLE instead of FETCH. From IDLE, a cycle with step=1 (rising level is not required) starts exactly one instruction. run=1 with step=0 waits in IDLE after reset.
- Compiled out: no `step` port; boundary and IDLE behaviour exactly as above.

Test Plan:
- Reset then run=1, imem always valid, program {16'h8123 at 0, 16'h8456 at 1}:
  - -> imem_addr 0,1; exec1 pulses 2 cycles apart; inst=16'h8123 then 16'h8456; pc=2.
- Load 16'hA000 at pc=3, dmem_ack asserted 4 cycles after MEMWAIT entry:
  - -> dmem_req high exactly 4 cycles; inst held 16'hA000; next fetch at address 4.
- Jump 16'h0010 at pc=5, ADDR_W=8:
  - -> next imem_addr=8'h10, not 6; exec1 pulses once for the jump.
- Halt 16'h4000:
  - -> halted=1 after exec1.
  - Then run toggling and imem_valid pulses cause no requests.
  - reset -> pc=RESET_PC, halted=0.
- PC wrap and stall: pc=8'hFF, imem_valid withheld 3 cycles then given:
  - -> imem_req held 3 extra cycles; pc becomes 8'h00.
- run dropped during MEMWAIT; reset asserted mid-FETCH:
  - -> load completes then IDLE with no new fetch.
  - Reset mid-FETCH -> IDLE next cycle, imem_req=0, inst=0.

Source files
------------

// File: rtl/arm_seq_ctrl.sv
// Instruction sequencer for the 16-bit Harvard datapath: fetch, execute strobe, load stall, jump/halt.
// Optional single-step control is compiled in with STEP_MODE_EN (adds the `step` input).
module arm_seq_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
`ifdef STEP_MODE_EN
    input  logic              step,
`endif
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [15:0]       inst,
    output logic              exec1,
    output logic              dmem_req,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    // state   | meaning
    // IDLE    | waiting for run (or step) at an instruction boundary
    // FETCH   | imem request outstanding at address pc
    // EXEC1   | one-cycle execute strobe, decode of inst
    // MEMWAIT | load in flight, waiting for dmem_ack
    // HALT    | stopped until reset
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC1   = 3'd2,
        MEMWAIT = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    state_t            state, state_nxt, boundary;
    logic [ADDR_W-1:0] pc_nxt;
    logic [15:0]       inst_nxt;
    logic              start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= PC_INIT;
            inst  <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
`ifdef STEP_MODE_EN
        // Every instruction returns to IDLE; a step cycle with run high launches the next one.
        boundary = IDLE;
        start    = run & step;
`else
        boundary = run ? FETCH : IDLE;
        start    = run;
`endif
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_valid) begin
                    inst_nxt  = imem_rdata;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = EXEC1;
                end
            end
            EXEC1: begin
                if (inst[15:13] == 3'b101) begin
                    state_nxt = MEMWAIT;
                end else if (inst[15]) begin
                    state_nxt = boundary;
                end else if (inst[14]) begin
                    state_nxt = HALT;
                end else begin
                    // Jump target replaces the increment done during FETCH.
                    pc_nxt    = inst[ADDR_W-1:0];
                    state_nxt = boundary;
                end
            end
            MEMWAIT: begin
                if (dmem_ack) state_nxt = boundary;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign exec1     = (state == EXEC1);
    assign dmem_req  = (state == MEMWAIT);
    assign halted    = (state == HALT);

endmodule
